// File: rtl/regfile_pkg.sv
// Shared constants and types for the register file.
// REGFILE_WRITE_BYPASS_EN enables write-through forwarding on reads.
package regfile_pkg;

  localparam int DATA_WIDTH = 32;
  localparam int ADDR_WIDTH = 5;
  localparam int NUM_REGS   = 2 ** ADDR_WIDTH;
  localparam int ZERO_REG   = 0;

`ifdef REGFILE_WRITE_BYPASS_EN
  localparam bit BYPASS_EN = 1'b1;
`else
  localparam bit BYPASS_EN = 1'b0;
`endif

  typedef logic [ADDR_WIDTH-1:0] reg_addr_t;
  typedef logic [DATA_WIDTH-1:0] reg_data_t;

endpackage

// File: rtl/reg_file_read_port.sv
// One combinational read port: decode, zero forcing, bypass mux.
// Bypass is compiled in when REGFILE_WRITE_BYPASS_EN is defined.
module reg_file_read_port
  import regfile_pkg::*;
#(
  parameter int DW = DATA_WIDTH,
  parameter int AW = ADDR_WIDTH,
  parameter int NR = 2 ** AW
) (
  input  logic                  rst_n,
  input  logic                  we,
  input  logic [AW-1:0]         wa,
  input  logic [DW-1:0]         wd,
  input  logic [AW-1:0]         ra,
  input  logic [NR-1:1][DW-1:0] regs,
  output logic [DW-1:0]         rd
);

  logic hit;

  // Forwarding hit: live write to the address being read.
  always_comb begin
    hit = 1'b0;
    if (BYPASS_EN && rst_n && we
        && (wa != AW'(ZERO_REG))
        && (ra == wa))
      hit = 1'b1;
  end

  // Select zero, forwarded data or stored entry.
  always_comb begin
    rd = '0;
    unique case (1'b1)
      (ra == AW'(ZERO_REG)): rd = '0;
      hit:                   rd = wd;
      default:               rd = regs[ra];
    endcase
  end

endmodule

// File: rtl/reg_file.sv
// 32x32 register file, two async reads, one sync write.
// REGFILE_WRITE_BYPASS_EN enables write-through forwarding on reads.
module reg_file
  import regfile_pkg::*;
#(
  parameter int DATA_WIDTH = regfile_pkg::DATA_WIDTH,
  parameter int ADDR_WIDTH = regfile_pkg::ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] wa,
  input  logic [DATA_WIDTH-1:0] wd,
  input  logic [ADDR_WIDTH-1:0] ra1,
  input  logic [ADDR_WIDTH-1:0] ra2,
  output logic [DATA_WIDTH-1:0] rd1,
  output logic [DATA_WIDTH-1:0] rd2
);

  localparam int NR = 2 ** ADDR_WIDTH;

  logic [NR-1:1][DATA_WIDTH-1:0] regs;

  // Storage update; reset wins, entry 0 is never stored.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      regs <= '0;
    end else if (we && (wa != ADDR_WIDTH'(ZERO_REG))) begin
      regs[wa] <= wd;
    end
  end

  reg_file_read_port #(
    .DW(DATA_WIDTH),
    .AW(ADDR_WIDTH),
    .NR(NR)
  ) u_rp1 (
    .rst_n(rst_n),
    .we   (we),
    .wa   (wa),
    .wd   (wd),
    .ra   (ra1),
    .regs (regs),
    .rd   (rd1)
  );

  reg_file_read_port #(
    .DW(DATA_WIDTH),
    .AW(ADDR_WIDTH),
    .NR(NR)
  ) u_rp2 (
    .rst_n(rst_n),
    .we   (we),
    .wa   (wa),
    .wd   (wd),
    .ra   (ra2),
    .regs (regs),
    .rd   (rd2)
  );

endmodule

// File: tb/tb_reg_file.sv
// Directed self-checking bench for reg_file.
// Define REGFILE_WRITE_BYPASS_EN to exercise forwarding.
module tb_reg_file;

  logic        clk;
  logic        rst_n;
  logic        we;
  logic [4:0]  wa;
  logic [31:0] wd;
  logic [4:0]  ra1;
  logic [4:0]  ra2;
  logic [31:0] rd1;
  logic [31:0] rd2;

  int checks;
  int failures;

  reg_file dut (
    .clk  (clk),
    .rst_n(rst_n),
    .we   (we),
    .wa   (wa),
    .wd   (wd),
    .ra1  (ra1),
    .ra2  (ra2),
    .rd1  (rd1),
    .rd2  (rd2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    we = 1'b1;
    wa = a;
    wd = d;
    @(posedge clk);
    #1;
    we = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    we = 1'b1;
    wa = 5'd9;
    wd = 32'h1234_5678;
    @(posedge clk);
    @(posedge clk);
    #1;
    we = 1'b0;
    for (int i = 0; i < 32; i++) begin
      ra1 = 5'(i);
      ra2 = 5'(31 - i);
      #1;
      checks++;
      if (rd1 !== 32'h0) begin
        failures++;
        $display("FAIL reset_rd1[%0d] got=%h exp=0", i, rd1);
      end
      checks++;
      if (rd2 !== 32'h0) begin
        failures++;
        $display("FAIL reset_rd2[%0d] got=%h exp=0", 31 - i, rd2);
      end
    end
    rst_n = 1'b1;
  endtask

  task automatic test_zero_write();
    wr(5'd0, 32'd30);
    ra1 = 5'd0;
    ra2 = 5'd0;
    #1;
    checks++;
    if (rd1 !== 32'h0) begin
      failures++;
      $display("FAIL zero_write rd1 got=%h exp=0", rd1);
    end
    checks++;
    if (rd2 !== 32'h0) begin
      failures++;
      $display("FAIL zero_write rd2 got=%h exp=0", rd2);
    end
  endtask

  task automatic test_write_latency();
    logic [31:0] pre_exp;
`ifdef REGFILE_WRITE_BYPASS_EN
    pre_exp = 32'd40;
`else
    pre_exp = 32'd0;
`endif
    ra1 = 5'd1;
    we = 1'b1;
    wa = 5'd1;
    wd = 32'd40;
    #1;
    checks++;
    if (rd1 !== pre_exp) begin
      failures++;
      $display("FAIL pre_edge rd1 got=%h exp=%h", rd1, pre_exp);
    end
    @(posedge clk);
    #1;
    we = 1'b0;
    checks++;
    if (rd1 !== 32'd40) begin
      failures++;
      $display("FAIL post_edge rd1 got=%h exp=%h", rd1, 32'd40);
    end
  endtask

  task automatic test_we_low();
    wr(5'd2, 32'd50);
    we = 1'b0;
    wa = 5'd2;
    wd = 32'd60;
    @(posedge clk);
    #1;
    ra2 = 5'd2;
    #1;
    checks++;
    if (rd2 !== 32'd50) begin
      failures++;
      $display("FAIL we_low rd2 got=%h exp=%h", rd2, 32'd50);
    end
  endtask

  task automatic test_async_read();
    wr(5'd3, 32'd70);
    wr(5'd4, 32'h0000_BEEF);
    ra2 = 5'd3;
    #1;
    checks++;
    if (rd2 !== 32'd70) begin
      failures++;
      $display("FAIL async_r3 rd2 got=%h exp=%h", rd2, 32'd70);
    end
    ra2 = 5'd4;
    #1;
    checks++;
    if (rd2 !== 32'h0000_BEEF) begin
      failures++;
      $display("FAIL async_r4 rd2 got=%h exp=%h", rd2, 32'h0000_BEEF);
    end
  endtask

  task automatic test_decode();
    wr(5'd31, 32'hFFFF_FFFF);
    wr(5'd16, 32'hA5A5_A5A5);
    wr(5'd8, 32'h0000_0001);
    ra1 = 5'd31;
    ra2 = 5'd16;
    #1;
    checks++;
    if (rd1 !== 32'hFFFF_FFFF) begin
      failures++;
      $display("FAIL dec_r31 rd1 got=%h exp=%h", rd1, 32'hFFFF_FFFF);
    end
    checks++;
    if (rd2 !== 32'hA5A5_A5A5) begin
      failures++;
      $display("FAIL dec_r16 rd2 got=%h exp=%h", rd2, 32'hA5A5_A5A5);
    end
    ra1 = 5'd8;
    ra2 = 5'd8;
    #1;
    checks++;
    if (rd1 !== 32'h1 || rd2 !== 32'h1) begin
      failures++;
      $display("FAIL same_addr rd1=%h rd2=%h exp=1", rd1, rd2);
    end
    ra1 = 5'd1;
    ra2 = 5'd2;
    #1;
    checks++;
    if (rd1 !== 32'd40 || rd2 !== 32'd50) begin
      failures++;
      $display("FAIL retain rd1=%h rd2=%h exp=40/50", rd1, rd2);
    end
  endtask

  task automatic test_reset_wins();
    wr(5'd5, 32'hDEAD_BEEF);
    ra1 = 5'd5;
    #1;
    checks++;
    if (rd1 !== 32'hDEAD_BEEF) begin
      failures++;
      $display("FAIL r5_set rd1 got=%h exp=%h", rd1, 32'hDEAD_BEEF);
    end
    rst_n = 1'b0;
    we = 1'b1;
    wa = 5'd5;
    wd = 32'd1;
    @(posedge clk);
    #1;
    checks++;
    if (rd1 !== 32'h0) begin
      failures++;
      $display("FAIL reset_wins rd1 got=%h exp=0", rd1);
    end
    we = 1'b0;
    for (int i = 0; i < 32; i++) begin
      ra2 = 5'(i);
      #1;
      checks++;
      if (rd2 !== 32'h0) begin
        failures++;
        $display("FAIL clear[%0d] rd2 got=%h exp=0", i, rd2);
      end
    end
    rst_n = 1'b1;
  endtask

  task automatic test_bypass();
    logic [31:0] exp_same;
    wr(5'd7, 32'd11);
`ifdef REGFILE_WRITE_BYPASS_EN
    exp_same = 32'd99;
`else
    exp_same = 32'd11;
`endif
    ra1 = 5'd7;
    ra2 = 5'd7;
    we = 1'b1;
    wa = 5'd7;
    wd = 32'd99;
    #1;
    checks++;
    if (rd1 !== exp_same || rd2 !== exp_same) begin
      failures++;
      $display("FAIL bypass rd1=%h rd2=%h exp=%h",
               rd1, rd2, exp_same);
    end
    @(posedge clk);
    #1;
    checks++;
    if (rd1 !== 32'd99 || rd2 !== 32'd99) begin
      failures++;
      $display("FAIL bypass_post rd1=%h rd2=%h exp=99", rd1, rd2);
    end
    wa = 5'd0;
    wd = 32'd123;
    ra1 = 5'd0;
    #1;
    checks++;
    if (rd1 !== 32'h0) begin
      failures++;
      $display("FAIL bypass_zero rd1 got=%h exp=0", rd1);
    end
    we = 1'b0;
  endtask

  initial begin
    checks = 0;
    failures = 0;
    rst_n = 1'b0;
    we = 1'b0;
    wa = '0;
    wd = '0;
    ra1 = '0;
    ra2 = '0;
    test_reset();
    test_zero_write();
    test_write_latency();
    test_we_low();
    test_async_read();
    test_decode();
    test_reset_wins();
    test_bypass();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
